// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller: light codes, phase codes and
// the per-phase duration lookup used by the FSM and its self-checks.
package traffic_pkg;

  typedef enum logic [1:0] {
    LightRed    = 2'd0,
    LightGreen  = 2'd1,
    LightYellow = 2'd2
  } light_e;

  typedef enum logic [2:0] {
    PhNsG  = 3'd0,
    PhNsY  = 3'd1,
    PhAr1  = 3'd2,
    PhEwG  = 3'd3,
    PhEwY  = 3'd4,
    PhAr2  = 3'd5,
    PhWalk = 3'd6
  } phase_e;

  localparam logic [2:0] PhIllegal = 3'd7;

  typedef enum logic {
    DirNs = 1'b0,
    DirEw = 1'b1
  } dir_e;

  function automatic int unsigned phase_duration(input logic [2:0]  ph,
                                                 input int unsigned green_t,
                                                 input int unsigned yellow_t,
                                                 input int unsigned allred_t,
                                                 input int unsigned walk_t);
    case (ph)
      PhNsG, PhEwG: return green_t;
      PhNsY, PhEwY: return yellow_t;
      PhAr1, PhAr2: return allred_t;
      PhWalk:       return walk_t;
      default:      return 1;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase countdown: loads a value on request, otherwise decrements to zero and holds.
// done_o flags the last cycle of the current phase.
module traffic_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == '0);

endmodule

// File: rtl/traffic_xsection_ctrl.sv
// Two-road intersection light controller with latched pedestrian walk phase.
// Define TRAFFIC_SENSE_EN to extend NS green while no EW vehicle or walk is waiting.
module traffic_xsection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GREEN_T  = 40,
  parameter int unsigned YELLOW_T = 5,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned WALK_T   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ped_req,
  input  logic             ew_car,
  output logic [1:0]       ns_light,
  output logic [1:0]       ew_light,
  output logic             walk,
  output logic             ped_ack,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] time_left,
  output logic             p1,
  output logic             p2,
  output logic             p3
);

  localparam int unsigned MaxGy  = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int unsigned MaxAw  = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
  localparam int unsigned MaxT   = (MaxGy > MaxAw) ? MaxGy : MaxAw;
  localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

  if (GREEN_T == 0 || YELLOW_T == 0 || ALLRED_T == 0 || WALK_T == 0) begin : g_zero_duration
    $error("traffic_xsection_ctrl: every phase duration must be at least 1");
  end
  if (longint'(MaxT) - 1 > CntMax) begin : g_counter_too_narrow
    $error("traffic_xsection_ctrl: CNT_W too narrow for the longest phase");
  end

  logic [2:0]       phase_d, phase_q;
  dir_e             next_dir_d, next_dir_q;
  logic             ped_pending_d, ped_pending_q;
  logic             ped_ack_d, ped_ack_q;
  logic             enter_walk;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_load_val, tmr_count;

  traffic_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .count_o    (tmr_count),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q       <= PhAr2;
      next_dir_q    <= DirNs;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    next_dir_d = next_dir_q;
    tmr_load   = 1'b0;
    if (phase_q == PhIllegal) begin
      phase_d  = PhAr2;
      tmr_load = 1'b1;
    end else if (tmr_done) begin
      tmr_load = 1'b1;
      case (phase_q)
        PhNsG: begin
`ifdef TRAFFIC_SENSE_EN
          phase_d = (!ew_car && !ped_pending_q) ? PhNsG : PhNsY;
`else
          phase_d = PhNsY;
`endif
        end
        PhNsY: phase_d = PhAr1;
        PhAr1: begin
          next_dir_d = DirEw;
          phase_d    = ped_pending_q ? PhWalk : PhEwG;
        end
        PhEwG: phase_d = PhEwY;
        PhEwY: phase_d = PhAr2;
        PhAr2: begin
          next_dir_d = DirNs;
          phase_d    = ped_pending_q ? PhWalk : PhNsG;
        end
        PhWalk:  phase_d = (next_dir_q == DirEw) ? PhEwG : PhNsG;
        default: phase_d = PhAr2;
      endcase
    end
    // Recovery from the illegal code lands in AR2 with an empty counter.
    tmr_load_val = (phase_q == PhIllegal) ? '0 :
                   CNT_W'(phase_duration(phase_d, GREEN_T, YELLOW_T, ALLRED_T, WALK_T) - 1);
    enter_walk    = (phase_d == PhWalk) && (phase_q != PhWalk);
    // A request arriving in the same cycle as the clear keeps the latch set.
    ped_pending_d = ped_req | (ped_pending_q & ~enter_walk);
    ped_ack_d     = enter_walk;
  end

`ifndef TRAFFIC_SENSE_EN
  logic unused_ew_car;
  assign unused_ew_car = ew_car;
`endif

  always_comb begin
    ns_light = LightRed;
    ew_light = LightRed;
    walk     = 1'b0;
    case (phase_q)
      PhNsG:   ns_light = LightGreen;
      PhNsY:   ns_light = LightYellow;
      PhEwG:   ew_light = LightGreen;
      PhEwY:   ew_light = LightYellow;
      PhWalk:  walk     = 1'b1;
      default: ;
    endcase
  end

  assign phase     = phase_q;
  assign time_left = tmr_count;
  assign ped_ack   = ped_ack_q;

  assign p1 = (phase_q == PhIllegal);
  assign p2 = !p1 && (32'(tmr_count) >
              (phase_duration(phase_q, GREEN_T, YELLOW_T, ALLRED_T, WALK_T) - 1));
  assign p3 = ((ns_light != LightRed) && (ew_light != LightRed)) ||
              (walk && ((ns_light != LightRed) || (ew_light != LightRed)));

endmodule
